// File: rtl/snk_engine.sv
// Snake body engine: owns the head/body coordinates, length, direction latch and the
// IDLE/RUN/DEAD game state, and exposes every segment plus valid bits to downstream logic.
//
// Ports:
//   CLK        clock, all logic on the rising edge
//   rst        synchronous active-high reset, overrides all other inputs
//   start      pulse: IDLE or DEAD -> RUN; the body is re-initialised
//   step       one-cycle move strobe from the game tick
//   dir        requested direction: 00 +x, 01 -x, 10 +y, 11 -y
//   grow       pulse from food logic; the snake lengthens on the next move
//   seg_xy     segment i at [i*2*COORD_BITS +: 2*COORD_BITS], {x, y}; segment 0 is the head
//   seg_valid  bit i set iff i < len
//   len        current length
//   head_x     segment 0 x
//   head_y     segment 0 y
//   running    state is RUN
//   dead       state is DEAD
//   full       len == MAX_LEN
module snk_engine #(
  parameter int unsigned COORD_BITS = 3,
  parameter int unsigned GRID_W     = 8,
  parameter int unsigned GRID_H     = 8,
  parameter int unsigned MAX_LEN    = 16,
  parameter int unsigned START_X    = 3,
  parameter int unsigned START_Y    = 3,
  parameter int unsigned WRAP       = 1
) (
  input  logic                              CLK,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              step,
  input  logic [1:0]                        dir,
  input  logic                              grow,
  output logic [MAX_LEN*2*COORD_BITS-1:0]   seg_xy,
  output logic [MAX_LEN-1:0]                seg_valid,
  output logic [$clog2(MAX_LEN+1)-1:0]      len,
  output logic [COORD_BITS-1:0]             head_x,
  output logic [COORD_BITS-1:0]             head_y,
  output logic                              running,
  output logic                              dead,
  output logic                              full
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned SW = 2 * COORD_BITS;

  localparam logic [COORD_BITS-1:0] XMax   = COORD_BITS'(GRID_W - 1);
  localparam logic [COORD_BITS-1:0] YMax   = COORD_BITS'(GRID_H - 1);
  localparam logic [COORD_BITS-1:0] XStart = COORD_BITS'(START_X);
  localparam logic [COORD_BITS-1:0] YStart = COORD_BITS'(START_Y);
  localparam logic [COORD_BITS-1:0] COne   = COORD_BITS'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDead} state_e;

  state_e                state_q;
  logic [COORD_BITS-1:0] seg_x_q [MAX_LEN];
  logic [COORD_BITS-1:0] seg_y_q [MAX_LEN];
  logic [LW-1:0]         len_q;
  logic [1:0]            dir_cur_q;
  logic [1:0]            dir_pend_q;
  logic                  grow_pend_q;

  logic                  dir_ok;
  logic [1:0]            move_dir;
  logic                  is_full;
  logic                  do_grow;
  logic [COORD_BITS-1:0] nx;
  logic [COORD_BITS-1:0] ny;
  logic                  oob;
  logic [LW-1:0]         coll_lim;
  logic                  hit;
  logic                  die;
  logic                  init;

  // Next-move decode: direction acceptance, next head, and tail-aware self-collision.
  always_comb begin
    // Reversal (same axis, other sign) is only illegal once there is a neck to run into.
    dir_ok   = !((dir[1] == dir_cur_q[1]) && (dir[0] != dir_cur_q[0]) && (len_q > LW'(1)));
    move_dir = dir_ok ? dir : dir_pend_q;
    is_full  = (len_q == LW'(MAX_LEN));
    do_grow  = (grow | grow_pend_q) & ~is_full;

    nx  = seg_x_q[0];
    ny  = seg_y_q[0];
    oob = 1'b0;
    unique case (move_dir)
      2'b00: begin
        if (seg_x_q[0] == XMax) begin
          nx  = '0;
          oob = (WRAP == 0);
        end else begin
          nx = seg_x_q[0] + COne;
        end
      end
      2'b01: begin
        if (seg_x_q[0] == '0) begin
          nx  = XMax;
          oob = (WRAP == 0);
        end else begin
          nx = seg_x_q[0] - COne;
        end
      end
      2'b10: begin
        if (seg_y_q[0] == YMax) begin
          ny  = '0;
          oob = (WRAP == 0);
        end else begin
          ny = seg_y_q[0] + COne;
        end
      end
      default: begin
        if (seg_y_q[0] == '0) begin
          ny  = YMax;
          oob = (WRAP == 0);
        end else begin
          ny = seg_y_q[0] - COne;
        end
      end
    endcase

    // Without growth the tail cell is vacated on this move, so it is not an obstacle.
    coll_lim = do_grow ? len_q : (len_q - LW'(1));
    hit      = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LW'(i) < coll_lim) && (seg_x_q[i] == nx) && (seg_y_q[i] == ny)) begin
        hit = 1'b1;
      end
    end
    die  = hit | oob;
    init = rst | (start & (state_q != StRun));
  end

  always_ff @(posedge CLK) begin
    if (init) begin
      state_q     <= rst ? StIdle : StRun;
      seg_x_q[0]  <= XStart;
      seg_y_q[0]  <= YStart;
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_x_q[i] <= '0;
        seg_y_q[i] <= '0;
      end
      len_q       <= LW'(1);
      dir_cur_q   <= 2'b00;
      dir_pend_q  <= 2'b00;
      grow_pend_q <= 1'b0;
    end else if (state_q == StRun) begin
      if (dir_ok) dir_pend_q <= dir;
      if (grow) grow_pend_q <= 1'b1;
      if (step) begin
        dir_cur_q   <= move_dir;
        grow_pend_q <= 1'b0;
        if (die) begin
          state_q <= StDead;
        end else begin
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x_q[i] <= seg_x_q[i-1];
            seg_y_q[i] <= seg_y_q[i-1];
          end
          seg_x_q[0] <= nx;
          seg_y_q[0] <= ny;
          if (do_grow) len_q <= len_q + LW'(1);
        end
      end
    end
  end

  always_comb begin
    seg_xy    = '0;
    seg_valid = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      seg_xy[i*SW +: SW] = {seg_x_q[i], seg_y_q[i]};
      seg_valid[i]       = (LW'(i) < len_q);
    end
  end

  assign len     = len_q;
  assign head_x  = seg_x_q[0];
  assign head_y  = seg_y_q[0];
  assign running = (state_q == StRun);
  assign dead    = (state_q == StDead);
  assign full    = is_full;

endmodule
